// File: rtl/pu_seq.sv
// Multi-cycle fetch/execute sequencer for the 16-bit processing unit.
// Shares one memory port between instruction fetch and LM/SM, and gates decoder enables once per instruction.
module pu_seq #(
  parameter int unsigned ICW = 16,
  parameter int unsigned TW  = 8,
  parameter int unsigned TMO = 200
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           step_en,
  input  logic           step,
  input  logic           mem_rdy,
  input  logic           dec_h,
  input  logic           dec_we,
  input  logic           dec_pcwe,
  input  logic           dec_dmwe,
  input  logic           dec_dms,
  output logic           mem_req,
  output logic           mem_sel,
  output logic           mem_we,
  output logic           ir_le,
  output logic           we_g,
  output logic           pcwe_g,
  output logic           pcinc,
  output logic           busy,
  output logic           halted,
  output logic           err,
  output logic [ICW-1:0] icnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]     r_state;
  logic [2:0]     w_state_nxt;
  logic [TW-1:0]  r_wcnt;
  logic [ICW-1:0] r_icnt;
  logic           w_retire;
  logic           w_timeout;

  // Last permitted wait cycle: a ready here still succeeds, no ready means the access has failed.
  assign w_timeout = !mem_rdy && (r_wcnt == TW'(TMO - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    mem_req     = 1'b0;
    mem_sel     = 1'b0;
    mem_we      = 1'b0;
    ir_le       = 1'b0;
    we_g        = 1'b0;
    pcwe_g      = 1'b0;
    pcinc       = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_le       = 1'b1;
          w_state_nxt = S_EXEC;
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end
      end
      S_EXEC: begin
        busy = 1'b1;
        if (dec_h) begin
          w_state_nxt = S_HALT;
        end else if (dec_dms || dec_dmwe) begin
          w_state_nxt = S_MEM;
        end else begin
          we_g        = dec_we;
          pcwe_g      = dec_pcwe;
          pcinc       = !dec_pcwe;
          w_retire    = 1'b1;
          w_state_nxt = step_en ? S_PAUSE : S_FETCH;
        end
      end
      S_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = dec_dmwe;
        if (mem_rdy) begin
          we_g        = dec_dms && dec_we;
          pcinc       = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = step_en ? S_PAUSE : S_FETCH;
        end else if (w_timeout) begin
          w_state_nxt = S_ERR;
        end
      end
      S_PAUSE: begin
        if (step || !step_en) w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_icnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Every entry into FETCH/MEM is a state change, so this restarts the wait budget per access.
      if (w_state_nxt != r_state) begin
        r_wcnt <= '0;
      end else if (!mem_rdy && (r_state == S_FETCH || r_state == S_MEM)) begin
        r_wcnt <= r_wcnt + TW'(1);
      end
      if (w_retire && (r_icnt != '1)) begin
        r_icnt <= r_icnt + ICW'(1);
      end
    end
  end

  assign icnt = r_icnt;

endmodule

// File: tb/tb_pu_seq.sv
// Self-checking bench for pu_seq: per-instruction transaction model predicts the cycle trace.
module tb_pu_seq;

  localparam int unsigned ICW = 4;
  localparam int unsigned TW  = 8;
  localparam int unsigned TMO = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, step_en, step, mem_rdy;
  logic dec_h, dec_we, dec_pcwe, dec_dmwe, dec_dms;
  logic mem_req, mem_sel, mem_we, ir_le, we_g, pcwe_g, pcinc, busy, halted, err;
  logic [ICW-1:0] icnt;
  logic [9:0] obs;

  int n_chk = 0;
  int n_err = 0;
  int m_icnt = 0;

  pu_seq #(.ICW(ICW), .TW(TW), .TMO(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step_en  (step_en),
    .step     (step),
    .mem_rdy  (mem_rdy),
    .dec_h    (dec_h),
    .dec_we   (dec_we),
    .dec_pcwe (dec_pcwe),
    .dec_dmwe (dec_dmwe),
    .dec_dms  (dec_dms),
    .mem_req  (mem_req),
    .mem_sel  (mem_sel),
    .mem_we   (mem_we),
    .ir_le    (ir_le),
    .we_g     (we_g),
    .pcwe_g   (pcwe_g),
    .pcinc    (pcinc),
    .busy     (busy),
    .halted   (halted),
    .err      (err),
    .icnt     (icnt)
  );

  assign obs = {mem_req, mem_sel, mem_we, ir_le, we_g, pcwe_g, pcinc, busy, halted, err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [9:0] ov(input logic req, sel, mwe, irle, weg, pcweg, inc,
                                    input logic bsy, hlt, er);
    return {req, sel, mwe, irle, weg, pcweg, inc, bsy, hlt, er};
  endfunction

  localparam logic [9:0] OutIdle = 10'b0;
  localparam logic [9:0] OutBusy = 10'b0000000100;

  task automatic retire();
    if (m_icnt < (1 << ICW) - 1) m_icnt++;
  endtask

  // Inputs are already driven; check outputs, then advance to just after the next edge.
  task automatic tick(input string tag, input logic [9:0] exp);
    #1;
    chk(tag, 32'(obs), 32'(exp));
    chk({tag, "_icnt"}, 32'(icnt), 32'(m_icnt));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_dec();
    dec_h    = rb();
    dec_we   = rb();
    dec_pcwe = rb();
    dec_dmwe = rb();
    dec_dms  = rb();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = rb();
    step  = rb();
    mem_rdy = rb();
    rand_dec();
    @(posedge clk);
    #1;
    m_icnt = 0;
    start  = 1'b1;
    tick("rst_hold", OutIdle);
    rst   = 1'b0;
    start = 1'b0;
    tick("idle", OutIdle);
    tick("idle2", OutIdle);
  endtask

  task automatic go();
    start = 1'b1;
    tick("start", OutIdle);
    start = 1'b0;
  endtask

  task automatic fetch_phase(input int flat, input logic sen);
    step_en = sen;
    for (int i = 0; i <= flat; i++) begin
      rand_dec();
      step    = rb();
      start   = rb();
      mem_rdy = (i == flat);
      tick("fetch", ov(1, 0, 0, mem_rdy, 0, 0, 0, 1, 0, 0));
    end
  endtask

  task automatic exec_phase(input logic h, we, pcwe, dmwe, dms, input int mlat,
                            input logic mem_fail);
    dec_h    = h;
    dec_we   = we;
    dec_pcwe = pcwe;
    dec_dmwe = dmwe;
    dec_dms  = dms;
    mem_rdy  = rb();
    step     = rb();
    start    = rb();
    if (h) begin
      tick("exec_halt", OutBusy);
    end else if (dmwe || dms) begin
      tick("exec_mem", OutBusy);
      if (mem_fail) begin
        for (int i = 0; i < int'(TMO); i++) begin
          mem_rdy = 1'b0;
          step    = rb();
          tick("mem_wait", ov(1, 1, dmwe, 0, 0, 0, 0, 1, 0, 0));
        end
      end else begin
        for (int j = 0; j <= mlat; j++) begin
          logic last;
          last    = (j == mlat);
          mem_rdy = last;
          step    = rb();
          tick("mem", ov(1, 1, dmwe, 0, last & dms & we, 0, last, 1, 0, 0));
        end
        retire();
      end
    end else begin
      tick("exec", ov(0, 0, 0, 0, we, pcwe, !pcwe, 1, 0, 0));
      retire();
    end
  endtask

  task automatic pause(input int waits, input logic via_step);
    for (int k = 0; k < waits; k++) begin
      step_en = 1'b1;
      step    = 1'b0;
      mem_rdy = rb();
      rand_dec();
      tick("pause", OutIdle);
    end
    if (via_step) begin
      step = 1'b1;
    end else begin
      step_en = 1'b0;
      step    = 1'b0;
    end
    tick("pause_go", OutIdle);
  endtask

  task automatic sticky(input string tag, input int n, input logic [9:0] exp);
    for (int k = 0; k < n; k++) begin
      start   = rb();
      step    = rb();
      step_en = rb();
      mem_rdy = rb();
      rand_dec();
      tick(tag, exp);
    end
  endtask

  task automatic rand_instr(input logic sen);
    int kind;
    int flat;
    int mlat;
    kind = $urandom_range(0, 3);
    flat = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 20) : $urandom_range(0, 3);
    mlat = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 20) : $urandom_range(0, 3);
    fetch_phase(flat, sen);
    case (kind)
      0:       exec_phase(0, rb(), 0, 0, 0, 0, 0);
      1:       exec_phase(0, rb(), 1, 0, 0, 0, 0);
      2:       exec_phase(0, rb(), rb(), 1, 0, mlat, 0);
      default: exec_phase(0, rb(), rb(), 0, 1, mlat, 0);
    endcase
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step_en = 1'b0; step = 1'b0; mem_rdy = 1'b0;
    dec_h = 1'b0; dec_we = 1'b0; dec_pcwe = 1'b0; dec_dmwe = 1'b0; dec_dms = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait CAL stream: one instruction every two cycles.
    do_reset();
    go();
    for (int n = 0; n < 3; n++) begin
      fetch_phase(0, 1'b0);
      exec_phase(0, 1, 0, 0, 0, 0, 0);
    end
    chk("cal_icnt3", 32'(icnt), 32'd3);

    // Taken branch behind a 3-cycle fetch wait, then SM and LM with 2 waits each.
    fetch_phase(3, 1'b0);
    exec_phase(0, 0, 1, 0, 0, 0, 0);
    fetch_phase(0, 1'b0);
    exec_phase(0, 1, 0, 1, 0, 2, 0);
    fetch_phase(1, 1'b0);
    exec_phase(0, 1, 0, 0, 1, 2, 0);

    // Single-step with step held high, then dropping step_en.
    for (int n = 0; n < 3; n++) begin
      fetch_phase($urandom_range(0, 2), 1'b1);
      exec_phase(0, 1, 0, 0, 0, 0, 0);
      pause(0, 1'b1);
    end
    fetch_phase(0, 1'b1);
    exec_phase(0, 1, 0, 0, 1, 1, 0);
    pause(3, 1'b0);
    fetch_phase(0, 1'b0);
    exec_phase(0, 0, 0, 0, 0, 0, 0);

    // Halt is sticky and freezes icnt; reset clears it.
    fetch_phase(1, 1'b0);
    exec_phase(1, 1, 1, 1, 1, 0, 0);
    sticky("halt", 8, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    do_reset();

    // Fetch timeout: ready on the last permitted cycle succeeds; one more wait is an error.
    go();
    fetch_phase(int'(TMO) - 1, 1'b0);
    exec_phase(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < int'(TMO); i++) begin
      mem_rdy = 1'b0;
      rand_dec();
      tick("tmo_fetch", ov(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    end
    sticky("err", 6, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    do_reset();

    // Data-access timeout.
    go();
    fetch_phase(0, 1'b0);
    exec_phase(0, 1, 0, 0, 1, 0, 1);
    sticky("err_mem", 4, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    do_reset();

    // Reset in the middle of a data access.
    go();
    fetch_phase(1, 1'b0);
    dec_h = 1'b0; dec_we = 1'b0; dec_pcwe = 1'b0; dec_dmwe = 1'b1; dec_dms = 1'b0;
    tick("exec_sm", OutBusy);
    mem_rdy = 1'b0;
    tick("mem_sm", ov(1, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    rst = 1'b1;
    tick("mem_rst", ov(1, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    rst    = 1'b0;
    m_icnt = 0;
    tick("after_rst", OutIdle);

    // Randomized sessions; icnt is narrow here so saturation is exercised.
    for (int s = 0; s < 3; s++) begin
      do_reset();
      go();
      for (int n = 0; n < 40; n++) begin
        logic sen;
        sen = ($urandom_range(0, 3) == 0);
        rand_instr(sen);
        if (sen) pause($urandom_range(0, 3), rb());
      end
      fetch_phase($urandom_range(0, 3), 1'b0);
      exec_phase(1, rb(), rb(), rb(), rb(), 0, 0);
      sticky("halt_r", 3, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
